mlp_layer_sequencer: RTL and testbench

Initiator side of the processing-unit (PU) start/ready handshake. Walks one MLP layer by issuing one `pu_start` per (neuron, input) pair and waiting for the PU's `ready` before the next. Generates weight/input addresses, clears the accumulator per neuron, reports per-neuron and per-layer completion. Sits between the top-level network controller and the PU datapath; a watchdog flags a PU that never answers.

---
 rtl/mlp_pkg.sv | 14 +
 rtl/pu_watchdog.sv | 32 +++
 rtl/mlp_layer_sequencer.sv | 124 ++++++++++++
 tb/tb_mlp_layer_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared types and defaults for the MLP layer sequencer and its PU watchdog.
package mlp_pkg;
    typedef enum logic [2:0] {IDLE, CLR, ISSUE, WAIT, NDONE, DONE, ERR} state_e;

    localparam int DEF_N_IN     = 62;
    localparam int DEF_N_NEURON = 10;
    localparam int DEF_TIMEOUT  = 15;
    localparam int PU_LATENCY   = 3;

    // Index width for a 0..n-1 counter, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pu_watchdog.sv
// Clearable saturating counter that flags the last WAIT cycle a PU may answer in.
module pu_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT);
    // Count is 0 in the first WAIT cycle, so expiry at TIMEOUT-2 puts ERR
    // exactly TIMEOUT cycles after the pu_start cycle.
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && !expired)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mlp_layer_sequencer.sv
// Walks one MLP layer: one PU start/ready handshake per (neuron, input) pair,
// with accumulator clears, completion pulses and a PU timeout watchdog.
module mlp_layer_sequencer
    import mlp_pkg::*;
#(
    parameter int N_IN     = DEF_N_IN,
    parameter int N_NEURON = DEF_N_NEURON,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int IN_W     = idx_w(N_IN),
    parameter int NR_W     = idx_w(N_NEURON)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            layer_start,
    input  logic            pu_ready,
    output logic            pu_start,
    output logic            acc_clr,
    output logic [IN_W-1:0] in_addr,
    output logic [NR_W-1:0] neuron_addr,
    output logic            neuron_done,
    output logic            layer_done,
    output logic            busy,
    output logic            err
);
    state_e          state_q, state_d;
    logic [IN_W-1:0] in_addr_q, in_addr_d;
    logic [NR_W-1:0] neuron_addr_q, neuron_addr_d;
    logic            pu_start_q, acc_clr_q, neuron_done_q, layer_done_q, busy_q, err_q;
    logic            pu_start_d, acc_clr_d, neuron_done_d, layer_done_d, busy_d, err_d;
    logic            wd_expired, last_in, last_nr;

    pu_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == ISSUE),
        .en      (state_q == WAIT),
        .expired (wd_expired)
    );

    assign last_in = (in_addr_q == IN_W'(N_IN - 1));
    assign last_nr = (neuron_addr_q == NR_W'(N_NEURON - 1));

    always_comb begin
        state_d       = state_q;
        in_addr_d     = in_addr_q;
        neuron_addr_d = neuron_addr_q;
        unique case (state_q)
            IDLE, ERR: if (layer_start) begin
                state_d       = CLR;
                in_addr_d     = '0;
                neuron_addr_d = '0;
            end
            CLR: begin
                state_d   = ISSUE;
                in_addr_d = '0;
            end
            ISSUE: state_d = WAIT;
            // Ready is checked before expiry so a late-but-valid answer wins.
            WAIT: if (pu_ready) begin
                if (last_in) state_d = NDONE;
                else begin
                    state_d   = ISSUE;
                    in_addr_d = in_addr_q + 1'b1;
                end
            end else if (wd_expired) begin
                state_d = ERR;
            end
            NDONE: if (last_nr) state_d = DONE;
            else begin
                state_d       = CLR;
                in_addr_d     = '0;
                neuron_addr_d = neuron_addr_q + 1'b1;
            end
            DONE: begin
                state_d       = IDLE;
                in_addr_d     = '0;
                neuron_addr_d = '0;
            end
            default: state_d = IDLE;
        endcase

        // Moore outputs registered off the next state so they align with it.
        pu_start_d    = (state_d == ISSUE);
        acc_clr_d     = (state_d == CLR);
        neuron_done_d = (state_d == NDONE);
        layer_done_d  = (state_d == DONE);
        busy_d        = (state_d == CLR) || (state_d == ISSUE) ||
                        (state_d == WAIT) || (state_d == NDONE);
        err_d         = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            in_addr_q     <= '0;
            neuron_addr_q <= '0;
            pu_start_q    <= 1'b0;
            acc_clr_q     <= 1'b0;
            neuron_done_q <= 1'b0;
            layer_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_addr_q     <= in_addr_d;
            neuron_addr_q <= neuron_addr_d;
            pu_start_q    <= pu_start_d;
            acc_clr_q     <= acc_clr_d;
            neuron_done_q <= neuron_done_d;
            layer_done_q  <= layer_done_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign pu_start    = pu_start_q;
    assign acc_clr     = acc_clr_q;
    assign in_addr     = in_addr_q;
    assign neuron_addr = neuron_addr_q;
    assign neuron_done = neuron_done_q;
    assign layer_done  = layer_done_q;
    assign busy        = busy_q;
    assign err         = err_q;
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Scoreboard bench: expected events queued by stimulus, popped by per-DUT monitors.
module tb_mlp_layer_sequencer;
    import mlp_pkg::*;

    localparam int TO = 15;
    localparam int EV_CLR = 0, EV_START = 1, EV_NDONE = 2, EV_LDONE = 3, EV_ERR = 4;

    typedef struct {
        int kind;
        int rel;
        int nr;
        int ia;
    } ev_t;

    logic clk = 1'b0, rst = 1'b1;
    logic ls0 = 1'b0, ls1 = 1'b0, sp_rdy0 = 1'b0, mdl_rdy0 = 1'b0, mdl_rdy1 = 1'b0;
    logic rdy0, rdy1;
    logic ps0, ac0, nd0, ld0, bz0, er0, ps1, ac1, nd1, ld1, bz1, er1;
    logic [0:0] ia0, na0, ia1, na1;

    ev_t exp0[$], exp1[$];
    int n_cmp = 0, n_bad = 0, cyc = 0, t0 = 0, t1 = 0;
    int pend0 = 0, pend1 = 0, lat0 = PU_LATENCY;
    bit en0 = 1'b1;
    logic er0_prev = 1'b0;

    assign rdy0 = mdl_rdy0 | sp_rdy0;
    assign rdy1 = mdl_rdy1;

    mlp_layer_sequencer #(.N_IN(2), .N_NEURON(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .layer_start(ls0), .pu_ready(rdy0),
        .pu_start(ps0), .acc_clr(ac0), .in_addr(ia0), .neuron_addr(na0),
        .neuron_done(nd0), .layer_done(ld0), .busy(bz0), .err(er0)
    );

    mlp_layer_sequencer #(.N_IN(1), .N_NEURON(1), .TIMEOUT(TO)) dut1 (
        .clk(clk), .rst(rst), .layer_start(ls1), .pu_ready(rdy1),
        .pu_start(ps1), .acc_clr(ac1), .in_addr(ia1), .neuron_addr(na1),
        .neuron_done(nd1), .layer_done(ld1), .busy(bz1), .err(er1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic push(input int which, input int kind, input int rel, input int nr, input int ia);
        ev_t e;
        e = '{kind, rel, nr, ia};
        if (which == 0) exp0.push_back(e);
        else            exp1.push_back(e);
    endtask

    // Expected event stream of a full layer, truncated after relative cycle 'upto'.
    task automatic push_layer(input int which, input int nin, input int nn, input int lat, input int upto);
        int t;
        t = 1;
        for (int n = 0; n < nn; n++) begin
            if (t <= upto) push(which, EV_CLR, t, n, 0);
            t++;
            for (int i = 0; i < nin; i++) begin
                if (t <= upto) push(which, EV_START, t, n, i);
                t += lat + 1;
            end
            if (t <= upto) push(which, EV_NDONE, t, n, nin - 1);
            t++;
        end
        if (t <= upto) push(which, EV_LDONE, t, nn - 1, nin - 1);
    endtask

    task automatic observe(input int which, input ev_t o);
        ev_t e;
        n_cmp++;
        if ((which == 0 && exp0.size() == 0) || (which == 1 && exp1.size() == 0)) begin
            n_bad++;
            $display("FAIL dut%0d unexpected event: kind=%0d rel=%0d nr=%0d in=%0d, want none",
                     which, o.kind, o.rel, o.nr, o.ia);
        end else begin
            e = (which == 0) ? exp0.pop_front() : exp1.pop_front();
            if (e.kind != o.kind || e.rel != o.rel || e.nr != o.nr || e.ia != o.ia) begin
                n_bad++;
                $display("FAIL dut%0d event: got kind=%0d rel=%0d nr=%0d in=%0d, want kind=%0d rel=%0d nr=%0d in=%0d",
                         which, o.kind, o.rel, o.nr, o.ia, e.kind, e.rel, e.nr, e.ia);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (ac0) observe(0, '{EV_CLR,   cyc - t0, int'(na0), int'(ia0)});
            if (ps0) observe(0, '{EV_START, cyc - t0, int'(na0), int'(ia0)});
            if (nd0) observe(0, '{EV_NDONE, cyc - t0, int'(na0), int'(ia0)});
            if (ld0) observe(0, '{EV_LDONE, cyc - t0, int'(na0), int'(ia0)});
            if (er0 && !er0_prev) observe(0, '{EV_ERR, cyc - t0, int'(na0), int'(ia0)});
            if (ac1) observe(1, '{EV_CLR,   cyc - t1, int'(na1), int'(ia1)});
            if (ps1) observe(1, '{EV_START, cyc - t1, int'(na1), int'(ia1)});
            if (nd1) observe(1, '{EV_NDONE, cyc - t1, int'(na1), int'(ia1)});
            if (ld1) observe(1, '{EV_LDONE, cyc - t1, int'(na1), int'(ia1)});
        end
        er0_prev <= er0;
    end

    // PU models: ready pulse 'lat' cycles after the pu_start cycle.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            pend0 = 0; mdl_rdy0 = 1'b0; pend1 = 0; mdl_rdy1 = 1'b0;
        end else begin
            mdl_rdy0 = 1'b0;
            mdl_rdy1 = 1'b0;
            if (pend0 > 0) begin pend0--; if (pend0 == 0) mdl_rdy0 = 1'b1; end
            if (pend1 > 0) begin pend1--; if (pend1 == 0) mdl_rdy1 = 1'b1; end
            if (ps0 && en0) pend0 = lat0;
            if (ps1) pend1 = PU_LATENCY;
        end
    end

    task automatic start0();
        @(negedge clk);
        ls0 = 1'b1;
        t0 = cyc;
        @(negedge clk);
        ls0 = 1'b0;
    endtask

    task automatic wait0(input int k);
        while (cyc - t0 < k) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, " pu_start"}, int'(ps0), 0);
        check({tag, " acc_clr"}, int'(ac0), 0);
        check({tag, " in_addr"}, int'(ia0), 0);
        check({tag, " neuron_addr"}, int'(na0), 0);
        check({tag, " neuron_done"}, int'(nd0), 0);
        check({tag, " layer_done"}, int'(ld0), 0);
        check({tag, " busy"}, int'(bz0), 0);
        check({tag, " err"}, int'(er0), 0);
    endtask

    initial begin
        #3 rst = 1'b0;
        #4 chk_zero("reset");
        check("reset dut1 busy", int'(bz1), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // 1x1 layer: start 2, neuron_done 6, layer_done 7
        push_layer(1, 1, 1, PU_LATENCY, 1000);
        @(negedge clk);
        ls1 = 1'b1;
        t1 = cyc;
        @(negedge clk);
        ls1 = 1'b0;
        while (cyc - t1 < 10) @(negedge clk);
        check("1x1 drained", exp1.size(), 0);
        check("1x1 busy idle", int'(bz1), 0);

        // Basic 2x2 layer
        push_layer(0, 2, 2, PU_LATENCY, 1000);
        start0();
        wait0(22);
        check("basic busy@22", int'(bz0), 0);
        check("basic drained", exp0.size(), 0);

        // Spurious ready outside WAIT and layer_start while busy
        push_layer(0, 2, 2, PU_LATENCY, 1000);
        @(negedge clk);
        ls0 = 1'b1; sp_rdy0 = 1'b1; t0 = cyc;
        @(negedge clk) ls0 = 1'b0;
        wait0(3); sp_rdy0 = 1'b0;
        wait0(4); ls0 = 1'b1;
        wait0(5); ls0 = 1'b0;
        wait0(10); ls0 = 1'b1; sp_rdy0 = 1'b1;
        wait0(11); ls0 = 1'b0;
        wait0(13); sp_rdy0 = 1'b0;
        wait0(23);
        check("spurious drained", exp0.size(), 0);

        // PU never answers
        en0 = 1'b0;
        push(0, EV_CLR, 1, 0, 0);
        push(0, EV_START, 2, 0, 0);
        push(0, EV_ERR, 17, 0, 0);
        start0();
        wait0(16); check("timeout err@16", int'(er0), 0);
        wait0(17); check("timeout err@17", int'(er0), 1);
        check("timeout busy@17", int'(bz0), 0);
        wait0(20);
        check("timeout err sticky", int'(er0), 1);
        check("timeout in_addr", int'(ia0), 0);
        check("timeout drained", exp0.size(), 0);
        en0 = 1'b1;
        push_layer(0, 2, 2, PU_LATENCY, 1000);
        start0();
        check("restart err cleared", int'(er0), 0);
        check("restart busy", int'(bz0), 1);
        wait0(23);
        check("restart drained", exp0.size(), 0);

        // Ready on the watchdog's last cycle is accepted
        lat0 = TO - 1;
        push_layer(0, 2, 2, TO - 1, 1000);
        start0();
        wait0(67);
        check("ready-wins err", int'(er0), 0);
        check("ready-wins drained", exp0.size(), 0);
        lat0 = PU_LATENCY;

        // Reset in WAIT of neuron 1
        push_layer(0, 2, 2, PU_LATENCY, 13);
        start0();
        wait0(13);
        rst = 1'b0;
        #1 chk_zero("midreset");
        repeat (3) @(negedge clk);
        check("midreset drained", exp0.size(), 0);
        rst = 1'b1;
        push_layer(0, 2, 2, PU_LATENCY, 1000);
        start0();
        wait0(23);
        check("post-reset drained", exp0.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
